kb_cmd_ctrl: RTL



---
 rtl/kb_ctrl_pkg.sv | 57 +++++
 rtl/kb_cmd_ctrl_dir_queue.sv | 55 +++++
 rtl/kb_cmd_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/kb_ctrl_pkg.sv
// Shared scan-code constants, direction encoding and controller state types
// for the keyboard command controller.
package kb_ctrl_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RT    = 8'h74;
  localparam logic [7:0] SC_DN    = 8'h72;
  localparam logic [7:0] SC_LT    = 8'h6B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {HS_WAIT_HI, HS_CAPTURE, HS_WAIT_LO} hs_state_e;
  typedef enum logic [1:0] {PS_IDLE, PS_EXT, PS_BRK, PS_EXT_BRK} ps_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] dir;
  } key_t;

  function automatic key_t map_p1(input logic [7:0] code);
    key_t k;
    k = '{hit: 1'b1, dir: DIR_UP};
    case (code)
      SC_W:    k.dir = DIR_UP;
      SC_D:    k.dir = DIR_RIGHT;
      SC_S:    k.dir = DIR_DOWN;
      SC_A:    k.dir = DIR_LEFT;
      default: k.hit = 1'b0;
    endcase
    return k;
  endfunction

  function automatic key_t map_p2(input logic [7:0] code);
    key_t k;
    k = '{hit: 1'b1, dir: DIR_UP};
    case (code)
      SC_UP:   k.dir = DIR_UP;
      SC_RT:   k.dir = DIR_RIGHT;
      SC_DN:   k.dir = DIR_DOWN;
      SC_LT:   k.dir = DIR_LEFT;
      default: k.hit = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/kb_cmd_ctrl_dir_queue.sv
// Per-player turn queue: filters repeats, reversals and overflow on push,
// and hands the head to the current direction on each game tick.
module dir_queue
  import kb_ctrl_pkg::*;
#(
  parameter int         QDEPTH = 2,
  parameter logic [1:0] INIT   = DIR_RIGHT
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       push_en,
  input  logic [1:0] push_dir,
  input  logic       tick,
  output logic [1:0] cur_dir
);

  localparam int PW = $clog2(QDEPTH);

  logic [1:0]  mem_q [QDEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic [1:0]  cur_q, cur_d, ref_dir;
  logic        pop, accept;

  // Pop is resolved first so the push filter sees the post-pop reference.
  always_comb begin
    pop     = tick && (cnt_q != '0);
    cnt_d   = cnt_q - (PW+1)'(pop);
    cur_d   = pop ? mem_q[rd_q] : cur_q;
    ref_dir = (cnt_d != '0) ? mem_q[wr_q - PW'(1)] : cur_d;
    accept  = push_en && (push_dir != ref_dir) && (push_dir != (ref_dir ^ 2'b10))
              && (cnt_d != (PW+1)'(QDEPTH));
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      cur_q <= INIT;
    end else begin
      cur_q <= cur_d;
      rd_q  <= rd_q + PW'(pop);
      wr_q  <= wr_q + PW'(accept);
      cnt_q <= cnt_d + (PW+1)'(accept);
    end
  end

  always_ff @(posedge board_clk) begin
    if (accept) mem_q[wr_q] <= push_dir;
  end

  assign cur_dir = cur_q;

endmodule

// File: rtl/kb_cmd_ctrl.sv
// Keyboard command controller: scan-code handshake, Set-2 prefix parser and
// per-player turn queues feeding the Tron game core.
module kb_cmd_ctrl
  import kb_ctrl_pkg::*;
#(
  parameter int         QDEPTH         = 2,
  parameter int         PREFIX_TIMEOUT = 1000000,
  parameter logic [1:0] P1_INIT        = 2'd1,
  parameter logic [1:0] P2_INIT        = 2'd3
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       scan_ready,
  input  logic [7:0] scan_code,
  output logic       read,
  input  logic       tick,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       start_pulse,
  output logic       esc_pulse,
  output logic [7:0] last_code
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  logic          sr_meta_q, sr_s_q;
  hs_state_e     hs_q;
  logic          read_q;
  logic [7:0]    byte_q, last_code_q;
  ps_state_e     ps_q;
  logic [TW-1:0] tmo_q;
  logic          p1_push_q, p2_push_q, start_cmd_q, esc_cmd_q;
  logic [1:0]    p1_pdir_q, p2_pdir_q;
  logic          start_pulse_q, esc_pulse_q;
  key_t          k1, k2;

  always_ff @(posedge board_clk) begin
    if (reset) begin
      sr_meta_q <= 1'b0;
      sr_s_q    <= 1'b0;
    end else begin
      sr_meta_q <= scan_ready;
      sr_s_q    <= sr_meta_q;
    end
  end

  // Handshake: one capture per scan_ready assertion; read_q marks a fresh byte_q.
  always_ff @(posedge board_clk) begin
    if (reset) begin
      hs_q        <= HS_WAIT_HI;
      read_q      <= 1'b0;
      last_code_q <= 8'h00;
    end else begin
      read_q <= 1'b0;
      case (hs_q)
        HS_WAIT_HI: if (sr_s_q) begin
          hs_q        <= HS_CAPTURE;
          read_q      <= 1'b1;
          byte_q      <= scan_code;
          last_code_q <= scan_code;
        end
        HS_CAPTURE: hs_q <= HS_WAIT_LO;
        HS_WAIT_LO: if (!sr_s_q) hs_q <= HS_WAIT_HI;
        default:    hs_q <= HS_WAIT_HI;
      endcase
    end
  end

  assign k1 = map_p1(byte_q);
  assign k2 = map_p2(byte_q);

  // Parser decodes the captured byte one cycle after capture; strobes leave one cycle later.
  always_ff @(posedge board_clk) begin
    if (reset) begin
      ps_q          <= PS_IDLE;
      tmo_q         <= '0;
      p1_push_q     <= 1'b0;
      p2_push_q     <= 1'b0;
      start_cmd_q   <= 1'b0;
      esc_cmd_q     <= 1'b0;
      start_pulse_q <= 1'b0;
      esc_pulse_q   <= 1'b0;
    end else begin
      p1_push_q     <= 1'b0;
      p2_push_q     <= 1'b0;
      start_cmd_q   <= 1'b0;
      esc_cmd_q     <= 1'b0;
      start_pulse_q <= start_cmd_q;
      esc_pulse_q   <= esc_cmd_q;
      if (read_q) begin
        tmo_q <= '0;
        case (ps_q)
          PS_IDLE: begin
            if (byte_q == SC_E0)      ps_q <= PS_EXT;
            else if (byte_q == SC_F0) ps_q <= PS_BRK;
            else begin
              p1_push_q   <= k1.hit;
              p1_pdir_q   <= k1.dir;
              start_cmd_q <= (byte_q == SC_SPACE);
              esc_cmd_q   <= (byte_q == SC_ESC);
            end
          end
          PS_EXT: begin
            if (byte_q == SC_F0) ps_q <= PS_EXT_BRK;
            else begin
              ps_q      <= PS_IDLE;
              p2_push_q <= k2.hit;
              p2_pdir_q <= k2.dir;
            end
          end
          default: ps_q <= PS_IDLE;
        endcase
      end else if (ps_q != PS_IDLE) begin
        if (tmo_q == TMO_LAST) begin
          ps_q  <= PS_IDLE;
          tmo_q <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

  dir_queue #(.QDEPTH(QDEPTH), .INIT(P1_INIT)) u_p1_q (
    .board_clk (board_clk),
    .reset     (reset),
    .push_en   (p1_push_q),
    .push_dir  (p1_pdir_q),
    .tick      (tick),
    .cur_dir   (p1_dir)
  );

  dir_queue #(.QDEPTH(QDEPTH), .INIT(P2_INIT)) u_p2_q (
    .board_clk (board_clk),
    .reset     (reset),
    .push_en   (p2_push_q),
    .push_dir  (p2_pdir_q),
    .tick      (tick),
    .cur_dir   (p2_dir)
  );

  assign read        = read_q;
  assign last_code   = last_code_q;
  assign start_pulse = start_pulse_q;
  assign esc_pulse   = esc_pulse_q;

endmodule
